// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery controller: flushes the pipeline, walks the ROB youngest-to-oldest
// restoring RAT mappings and freeing pregs, then redirects fetch and truncates the ROB tail.
module recovery_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_W     = $clog2(ROB_DEPTH),
  parameter int AREG_W    = 5,
  parameter int PREG_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mispredict_i,
  input  logic [31:0]       target_pc_i,
  input  logic [ROB_W-1:0]  recover_tag_i,
  input  logic [ROB_W-1:0]  rob_head_i,
  input  logic [ROB_W-1:0]  rob_tail_i,
  output logic [ROB_W-1:0]  rob_walk_idx_o,
  input  logic              rob_walk_rd_used_i,
  input  logic [AREG_W-1:0] rob_walk_ard_i,
  input  logic [PREG_W-1:0] rob_walk_prd_i,
  input  logic [PREG_W-1:0] rob_walk_old_prd_i,
  output logic              flush_o,
  output logic              busy_o,
  output logic              rat_restore_valid_o,
  output logic [AREG_W-1:0] rat_restore_ard_o,
  output logic [PREG_W-1:0] rat_restore_prd_o,
  output logic              fl_free_valid_o,
  output logic [PREG_W-1:0] fl_free_prd_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  output logic              rob_tail_set_o,
  output logic [ROB_W-1:0]  rob_tail_val_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_WALK     = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [ROB_W-1:0] tag_q, tag_d;
  logic [ROB_W-1:0] ptr_q, ptr_d;

  logic [ROB_W-1:0] cur_age, new_age, tag_eff, ptr_dec;
  logic             take_older, restore;

  // A second mispredict only wins if its branch is older than the one being recovered.
  assign cur_age    = tag_q - rob_head_i;
  assign new_age    = recover_tag_i - rob_head_i;
  assign take_older = mispredict_i && (new_age < cur_age) &&
                      ((state_q == S_FLUSH) || (state_q == S_WALK));
  assign tag_eff    = take_older ? recover_tag_i : tag_q;
  assign ptr_dec    = ptr_q - ROB_W'(1);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    if (take_older) begin
      tgt_d = target_pc_i;
      tag_d = recover_tag_i;
    end
    case (state_q)
      S_IDLE: begin
        if (mispredict_i) begin
          tgt_d   = target_pc_i;
          tag_d   = recover_tag_i;
          ptr_d   = rob_tail_i - ROB_W'(1);
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:  state_d = (ptr_q == tag_eff) ? S_REDIRECT : S_WALK;
      S_WALK: begin
        ptr_d = ptr_dec;
        if (ptr_dec == tag_eff) state_d = S_REDIRECT;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decode from registered state only, so reset silences them immediately.
  assign restore = (state_q == S_WALK) && rob_walk_rd_used_i && (rob_walk_ard_i != '0);

  always_comb begin
    flush_o             = 1'b0;
    busy_o              = (state_q != S_IDLE);
    rob_walk_idx_o      = '0;
    rat_restore_valid_o = 1'b0;
    rat_restore_ard_o   = '0;
    rat_restore_prd_o   = '0;
    fl_free_valid_o     = 1'b0;
    fl_free_prd_o       = '0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = '0;
    rob_tail_set_o      = 1'b0;
    rob_tail_val_o      = '0;
    case (state_q)
      S_FLUSH: flush_o = 1'b1;
      S_WALK: begin
        rob_walk_idx_o = ptr_q;
        if (restore) begin
          rat_restore_valid_o = 1'b1;
          rat_restore_ard_o   = rob_walk_ard_i;
          rat_restore_prd_o   = rob_walk_old_prd_i;
          fl_free_valid_o     = 1'b1;
          fl_free_prd_o       = rob_walk_prd_i;
        end
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = tgt_q;
        rob_tail_set_o   = 1'b1;
        rob_tail_val_o   = tag_q + ROB_W'(1);
      end
      default: ;
    endcase
  end

endmodule
